fft_frame_scheduler: RTL
========================

Name: fft_frame_scheduler

Overview:
Sequences the 32-point FFT core for the keyword-spotting front end. Buffers a continuous audio sample stream in a ring buffer and cuts it into overlapping frames (FRAME_LEN window, HOP advance). Streams each frame into the FFT over its valid/ready handshake, then collects the 32 output bins and re-emits them tagged with bin index and frame id. Sits between the audio sample source and the mel/feature stage.

Parameters:
DATA_WIDTH, 16, sample and bin width (signed)
FRAME_LEN, 32, samples per frame; equals FFT size
HOP, 16, samples advanced between frame starts; 1..FRAME_LEN
BUF_DEPTH, 64, ring buffer entries; power of 2, >= FRAME_LEN+HOP
TIMEOUT, 255, max DRAIN cycles without a bin before error

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  permits new frame launches
sample_valid  in  1  audio sample strobe; no backpressure
sample_data  in  DATA_WIDTH  signed audio sample
fft_ready  in  1  FFT core idle and able to accept a frame
fft_valid_in  out  1  sample beat to FFT (registered)
fft_real_in  out  DATA_WIDTH  real part to FFT (registered)
fft_imag_in  out  DATA_WIDTH  imaginary part, constant 0
fft_valid_out  in  1  FFT bin beat
fft_real_out  in  DATA_WIDTH  FFT bin real
fft_imag_out  in  DATA_WIDTH  FFT bin imag
bin_valid  out  1  tagged bin beat
bin_real  out  DATA_WIDTH  bin real
bin_imag  out  DATA_WIDTH  bin imag
bin_index  out  5  bin number 0..31
bin_last  out  1  high with bin_index 31
frame_id  out  8  frame number of current bin, wraps 255->0
busy  out  1  state != IDLE
overrun_count  out  16  samples dropped on full buffer, saturating
timeout_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset: all outputs 0, state IDLE, wr_ptr=rd_base=occupancy=0, frame counter 0, ring contents don't-care.
- Sample write (any state, regardless of enable): if sample_valid and (occupancy<BUF_DEPTH or a HOP release occurs this cycle), write ring[wr_ptr], wr_ptr++ (wraps mod BUF_DEPTH). Otherwise drop and increment overrun_count (saturate at 0xFFFF).
- occupancy next = occupancy + write_accepted - (release ? HOP : 0); both in same cycle are legal.
- IDLE -> FEED when enable && occupancy>=FRAME_LEN && fft_ready. feed_cnt=0.
- FEED: each cycle register fft_valid_in=1, fft_real_in=ring[(rd_base+feed_cnt) mod BUF_DEPTH]; feed_cnt++. 32 back-to-back beats, fft_ready not re-sampled. On feed_cnt==31: release (rd_base+=HOP mod BUF_DEPTH, occupancy-=HOP), -> DRAIN. fft_valid_in low the cycle after the 32nd beat.
- Frame samples are protected during FEED: occupancy drops only at release.
- DRAIN: each fft_valid_out beat is registered to bin_* one cycle later, bin_index=beat count, frame_id=frame counter. On the 32nd beat, bin_last=1, frame counter++, -> IDLE. wd_cnt resets on every beat. If wd_cnt reaches TIMEOUT, set timeout_err and -> IDLE with no frame counter increment.
- fft_valid_out outside DRAIN is ignored. No bin_valid is produced.
- enable deassert mid-frame: the current FEED/DRAIN completes and no new launch occurs.
- Reset mid-frame: immediate return to reset values. The FFT core shares this reset.
- Latency: IDLE launch condition to first fft_valid_in = 1 cycle; fft_valid_out to bin_valid = 1 cycle.

Decomposition:
- Shared package kws_fft_pkg: FFT_SIZE=32, DATA_WIDTH, typedef sched_state_t {IDLE, FEED, DRAIN}.
- One sub-module, frame_ring_buf: BUF_DEPTH x DATA_WIDTH storage with write port and async read port.
- Pointer/occupancy logic stays in the scheduler.

Test Plan:
- Ramp samples 0..31 with enable=1 and fft_ready=1 -> 32 fft_valid_in beats carrying 0..31. Feed samples 32..47 -> second frame carries 16..47.
- FFT model returns bins k*100 -> bin_valid x32, bin_index 0..31, bin_last only on 31, frame_id 0 then 1.
- 80 samples with enable=0 -> occupancy 64, overrun_count=16, no fft_valid_in. Raise enable -> frame launches with samples 0..31.
- Sample arriving on the release cycle at occupancy=64 -> sample accepted, overrun_count unchanged, occupancy=49.
- FFT model never returns bins -> timeout_err=1 after 255 DRAIN cycles, busy=0, frame_id unchanged.
- Assert reset during FEED beat 10 -> all outputs 0 next cycle. After release, refill with 32 samples -> clean frame with frame_id=0.

Source files
------------

// File: rtl/kws_fft_pkg.sv
// Shared types and constants for the keyword-spotting FFT front end.
package kws_fft_pkg;
    localparam int FFT_SIZE   = 32;
    localparam int DATA_WIDTH = 16;
    localparam int BIN_IDX_W  = $clog2(FFT_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } sched_state_t;
endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Sample, FFT-core and tagged-bin signals of the frame scheduler.
interface fft_frame_scheduler_if
    import kws_fft_pkg::*;
#(
    parameter int DW = DATA_WIDTH
);
    logic                 enable;
    logic                 sample_valid;
    logic signed [DW-1:0] sample_data;
    logic                 fft_ready;
    logic                 fft_valid_in;
    logic signed [DW-1:0] fft_real_in;
    logic signed [DW-1:0] fft_imag_in;
    logic                 fft_valid_out;
    logic signed [DW-1:0] fft_real_out;
    logic signed [DW-1:0] fft_imag_out;
    logic                 bin_valid;
    logic signed [DW-1:0] bin_real;
    logic signed [DW-1:0] bin_imag;
    logic [4:0]           bin_index;
    logic                 bin_last;
    logic [7:0]           frame_id;
    logic                 busy;
    logic [15:0]          overrun_count;
    logic                 timeout_err;

    // Scheduler side.
    modport master (
        input  enable, sample_valid, sample_data, fft_ready,
               fft_valid_out, fft_real_out, fft_imag_out,
        output fft_valid_in, fft_real_in, fft_imag_in,
               bin_valid, bin_real, bin_imag, bin_index, bin_last,
               frame_id, busy, overrun_count, timeout_err
    );

    // Sample source, FFT core and feature stage side.
    modport slave (
        output enable, sample_valid, sample_data, fft_ready,
               fft_valid_out, fft_real_out, fft_imag_out,
        input  fft_valid_in, fft_real_in, fft_imag_in,
               bin_valid, bin_real, bin_imag, bin_index, bin_last,
               frame_id, busy, overrun_count, timeout_err
    );
endinterface

// File: rtl/frame_ring_buf.sv
// Audio sample ring storage: one synchronous write port, one combinational read port.
module frame_ring_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    i_wr_en,
    input  logic [AW-1:0]           i_wr_addr,
    input  logic signed [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]           i_rd_addr,
    output logic signed [WIDTH-1:0] o_rd_data
);
    logic signed [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fft_frame_scheduler.sv
// Cuts a continuous sample stream into overlapping frames, feeds them to the
// 32-point FFT and re-emits the returned bins tagged with index and frame id.
module fft_frame_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 32,
    parameter int HOP        = 16,
    parameter int BUF_DEPTH  = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    fft_frame_scheduler_if.master bus
);
    import kws_fft_pkg::*;

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int FW = $clog2(FRAME_LEN);
    localparam int WW = $clog2(TIMEOUT + 1);

    sched_state_t                r_state;
    logic [AW-1:0]               r_wr_ptr;
    logic [AW-1:0]               r_rd_base;
    logic [OW-1:0]               r_occupancy;
    logic [FW-1:0]               r_feed_cnt;
    logic [BIN_IDX_W-1:0]        r_beat_cnt;
    logic [WW-1:0]               r_wd_cnt;
    logic [7:0]                  r_frame_cnt;
    logic [15:0]                 r_overrun_count;
    logic                        r_timeout_err;
    logic                        r_fft_valid_in;
    logic signed [DATA_WIDTH-1:0] r_fft_real_in;
    logic                        r_bin_valid;
    logic signed [DATA_WIDTH-1:0] r_bin_real;
    logic signed [DATA_WIDTH-1:0] r_bin_imag;
    logic [BIN_IDX_W-1:0]        r_bin_index;
    logic                        r_bin_last;
    logic [7:0]                  r_frame_id;

    logic                        w_release;
    logic                        w_write_ok;
    logic                        w_launch;
    logic [AW-1:0]               w_rd_addr;
    logic signed [DATA_WIDTH-1:0] w_rd_data;

    // The HOP oldest samples are released only on the last feed beat, so the
    // frame being fed can never be overwritten by incoming audio.
    assign w_release  = (r_state == FEED) && (r_feed_cnt == FW'(FRAME_LEN - 1));
    assign w_write_ok = bus.sample_valid && ((r_occupancy < OW'(BUF_DEPTH)) || w_release);
    assign w_launch   = (r_state == IDLE) && bus.enable && bus.fft_ready
                        && (r_occupancy >= OW'(FRAME_LEN));
    assign w_rd_addr  = r_rd_base + AW'(r_feed_cnt);

    frame_ring_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ring (
        .clock     (clock),
        .i_wr_en   (w_write_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.sample_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_rd_base       <= '0;
            r_occupancy     <= '0;
            r_overrun_count <= '0;
        end else begin
            if (w_write_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else if (bus.sample_valid && (r_overrun_count != 16'hFFFF)) begin
                r_overrun_count <= r_overrun_count + 16'd1;
            end
            if (w_release) begin
                r_rd_base <= r_rd_base + AW'(HOP);
            end
            r_occupancy <= r_occupancy + OW'(w_write_ok) - (w_release ? OW'(HOP) : OW'(0));
        end
    end

    // Beat 0 is issued on the launch edge itself, giving one cycle of latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_feed_cnt     <= '0;
            r_beat_cnt     <= '0;
            r_wd_cnt       <= '0;
            r_frame_cnt    <= '0;
            r_timeout_err  <= 1'b0;
            r_fft_valid_in <= 1'b0;
            r_fft_real_in  <= '0;
            r_bin_valid    <= 1'b0;
            r_bin_real     <= '0;
            r_bin_imag     <= '0;
            r_bin_index    <= '0;
            r_bin_last     <= 1'b0;
            r_frame_id     <= '0;
        end else begin
            r_fft_valid_in <= 1'b0;
            r_bin_valid    <= 1'b0;
            r_bin_last     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_fft_valid_in <= 1'b1;
                        r_fft_real_in  <= w_rd_data;
                        r_feed_cnt     <= FW'(1);
                        r_state        <= FEED;
                    end
                end
                FEED: begin
                    r_fft_valid_in <= 1'b1;
                    r_fft_real_in  <= w_rd_data;
                    if (w_release) begin
                        r_feed_cnt <= '0;
                        r_beat_cnt <= '0;
                        r_wd_cnt   <= '0;
                        r_state    <= DRAIN;
                    end else begin
                        r_feed_cnt <= r_feed_cnt + FW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.fft_valid_out) begin
                        r_bin_valid <= 1'b1;
                        r_bin_real  <= bus.fft_real_out;
                        r_bin_imag  <= bus.fft_imag_out;
                        r_bin_index <= r_beat_cnt;
                        r_frame_id  <= r_frame_cnt;
                        r_wd_cnt    <= '0;
                        if (r_beat_cnt == BIN_IDX_W'(FFT_SIZE - 1)) begin
                            r_bin_last  <= 1'b1;
                            r_beat_cnt  <= '0;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                            r_state     <= IDLE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BIN_IDX_W'(1);
                        end
                    end else if (r_wd_cnt == WW'(TIMEOUT - 1)) begin
                        // Abandon the frame without advancing the frame counter.
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.fft_valid_in  = r_fft_valid_in;
    assign bus.fft_real_in   = r_fft_real_in;
    assign bus.fft_imag_in   = '0;
    assign bus.bin_valid     = r_bin_valid;
    assign bus.bin_real      = r_bin_real;
    assign bus.bin_imag      = r_bin_imag;
    assign bus.bin_index     = r_bin_index;
    assign bus.bin_last      = r_bin_last;
    assign bus.frame_id      = r_frame_id;
    assign bus.busy          = (r_state != IDLE);
    assign bus.overrun_count = r_overrun_count;
    assign bus.timeout_err   = r_timeout_err;
endmodule
